mux4_scanner: RTL

Sequencer that sits directly upstream and downstream of a 4-to-1 multiplexer: it drives the mux's 2-bit select line through channels 0..3, waits a programmable settle time on each channel, samples the mux output, and presents the four samples as one parallel word on a valid/ready handshake. It replaces hand-stepped select stimulus with a clocked, self-timed scan. Its outputs are the select line driven into the mux and the assembled word driven downstream.

---
 rtl/mux4_scan_pkg.sv | 15 +
 rtl/mux4_scanner_settle_timer.sv | 27 ++
 rtl/mux4_scanner.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux4_scan_pkg.sv
// rtl/mux4_scan_pkg.sv - shared types and constants for the 4-channel mux scanner
package mux4_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/mux4_scanner_settle_timer.sv
// rtl/mux4_scanner_settle_timer.sv - loadable down-counter flagging when it reaches zero
module settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Parks at zero so an idle timer never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux4_scanner.sv
// rtl/mux4_scanner.sv - steps a 4:1 mux select, samples each channel, emits the 4-bit word
module mux4_scanner
  import mux4_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mux_y,
  output logic [SEL_W-1:0] sel,
  output logic [NUM_CH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux4_scanner: SETTLE must be in 1..15");
  end

  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

  scan_state_t       state, state_next;
  logic              load;
  logic              zero;
  logic [NUM_CH-1:0] cap, cap_next;

  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (LOAD_VAL),
    .zero     (zero)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    cap_next   = cap;
    cap_next[sel] = mux_y;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SETTLE;
          load       = 1'b1;
        end
      end
      S_SETTLE: begin
        if (zero) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (sel == LAST_CH) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SETTLE;
          load       = 1'b1;
        end
      end
      S_DONE: begin
        if (ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The completed word goes straight from cap_next so data never shows a partial scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sel   <= '0;
      cap   <= '0;
      data  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            sel <= '0;
            cap <= '0;
          end
        end
        S_SAMPLE: begin
          cap <= cap_next;
          if (sel == LAST_CH) begin
            data <= cap_next;
          end else begin
            sel <= sel + 1'b1;
          end
        end
        S_DONE: begin
          if (ready) sel <= '0;
        end
        default: ;
      endcase
    end
  end

  assign valid = (state == S_DONE);
  assign busy  = (state != S_IDLE);

endmodule
